// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: opcodes, ALU op codes, branch/writeback encodings
// and the packed control bundle carried through the ID/EX register.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BGEZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGT   = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_NONE   = 3'b000;
  localparam logic [2:0] ALU_BRANCH = 3'b001;
  localparam logic [2:0] ALU_RTYPE  = 3'b010;
  localparam logic [2:0] ALU_SLT    = 3'b011;
  localparam logic [2:0] ALU_LUI    = 3'b100;
  localparam logic [2:0] ALU_GEZ    = 3'b101;
  localparam logic [2:0] ALU_ADD    = 3'b110;
  localparam logic [2:0] ALU_OR     = 3'b111;

  typedef enum logic [1:0] {
    BR_EQ  = 2'b00,
    BR_GT  = 2'b01,
    BR_GEZ = 2'b10,
    BR_NE  = 2'b11
  } brType_t;

  typedef enum logic [1:0] {
    MTR_ALU  = 2'b00,
    MTR_MEM  = 2'b01,
    MTR_LINK = 2'b11
  } memToReg_t;

  typedef struct packed {
    logic       regWrite;
    logic       aluSrc;
    logic       regDst;
    logic       branch;
    logic       jump;
    logic       memRead;
    logic       memWrite;
    logic       isOri;
    logic       isJal;
    logic       readDataReg;
    logic [2:0] aluOp;
    brType_t    branchType;
    memToReg_t  memToReg;
  } ctrlBundle_t;

endpackage

// File: rtl/ctrl_lut.sv
// Opcode to control-bundle lookup with source-register usage and illegal flag.
// Latency: combinational, no state.
// Backpressure: none; evaluated every cycle regardless of stall or flush.
module ctrl_lut
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]  opcode,
  output ctrlBundle_t ctrl,
  output logic        usesRs,
  output logic        usesRt,
  output logic        illegal
);

  always_comb begin
    ctrl             = '0;
    ctrl.readDataReg = 1'b1;
    usesRs           = 1'b1;
    usesRt           = 1'b0;
    illegal          = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = 1'b1;
        ctrl.aluOp    = ALU_RTYPE;
        usesRt        = 1'b1;
      end
      OP_ADDI: begin
        ctrl.regWrite = 1'b1;
        ctrl.aluSrc   = 1'b1;
        ctrl.aluOp    = ALU_ADD;
      end
      OP_SLTI: begin
        ctrl.regWrite = 1'b1;
        ctrl.aluSrc   = 1'b1;
        ctrl.aluOp    = ALU_SLT;
      end
      OP_LUI: begin
        ctrl.regWrite = 1'b1;
        ctrl.aluSrc   = 1'b1;
        ctrl.aluOp    = ALU_LUI;
        usesRs        = 1'b0;
      end
      OP_ORI: begin
        ctrl.regWrite = 1'b1;
        ctrl.aluSrc   = 1'b1;
        ctrl.aluOp    = ALU_OR;
        ctrl.isOri    = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch     = 1'b1;
        ctrl.aluOp      = ALU_BRANCH;
        ctrl.branchType = BR_EQ;
        usesRt          = 1'b1;
      end
      OP_BNE: begin
        ctrl.branch     = 1'b1;
        ctrl.aluOp      = ALU_BRANCH;
        ctrl.branchType = BR_NE;
        usesRt          = 1'b1;
      end
      OP_BGT: begin
        ctrl.branch     = 1'b1;
        ctrl.aluOp      = ALU_BRANCH;
        ctrl.branchType = BR_GT;
        usesRt          = 1'b1;
      end
      OP_BGEZ: begin
        // Compares rs against zero, so the register-file read path is bypassed.
        ctrl.branch      = 1'b1;
        ctrl.aluOp       = ALU_GEZ;
        ctrl.branchType  = BR_GEZ;
        ctrl.readDataReg = 1'b0;
      end
      OP_LW: begin
        ctrl.regWrite = 1'b1;
        ctrl.aluSrc   = 1'b1;
        ctrl.aluOp    = ALU_ADD;
        ctrl.memRead  = 1'b1;
        ctrl.memToReg = MTR_MEM;
      end
      OP_SW: begin
        ctrl.aluOp    = ALU_ADD;
        ctrl.memWrite = 1'b1;
        usesRt        = 1'b1;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
        usesRs    = 1'b0;
      end
      OP_JAL: begin
        ctrl.jump        = 1'b1;
        ctrl.regWrite    = 1'b1;
        ctrl.memToReg    = MTR_LINK;
        ctrl.isJal       = 1'b1;
        ctrl.readDataReg = 1'b0;
        usesRs           = 1'b0;
      end
      default: begin
        ctrl    = '0;
        usesRs  = 1'b0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pipe_decoder.sv
// Registered ID-stage decoder with ID/EX register, load-use detection and CPI counters.
// Latency: 1 cycle from instr_i to outputs; stall_o is same-cycle combinational.
// Backpressure: stall_o holds IF and IF/ID for one cycle while a bubble enters ID/EX.
module pipe_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_OP_W  = 3,
  parameter int CNT_W     = 16,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         instr_i,
  input  logic                instr_valid_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                valid_o,
  output logic                reg_write_o,
  output logic                alu_src_o,
  output logic                reg_dst_o,
  output logic                branch_o,
  output logic                jump_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                is_ori_o,
  output logic                is_jal_o,
  output logic                read_data_reg_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic [1:0]          branch_type_o,
  output logic [1:0]          mem_to_reg_o,
  output logic [4:0]          rs_o,
  output logic [4:0]          rt_o,
  output logic [4:0]          rd_o,
  output logic [15:0]         imm_o,
  output logic [25:0]         jaddr_o,
  output logic                illegal_o,
  output logic [CNT_W-1:0]    issued_cnt_o,
  output logic [CNT_W-1:0]    bubble_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrlBundle_t         lutCtrl;
  logic                usesRs;
  logic                usesRt;
  logic                lutIllegal;
  ctrlBundle_t         ctrlQ;
  logic                validQ;
  logic                illegalQ;
  logic [4:0]          rsQ;
  logic [4:0]          rtQ;
  logic [4:0]          rdQ;
  logic [15:0]         immQ;
  logic [25:0]         jaddrQ;
  logic [CNT_W-1:0]    issuedQ;
  logic [CNT_W-1:0]    bubbleQ;
  logic                hazardHit;
  logic                loadBubble;
  logic                takeIllegal;

  ctrl_lut uLut (
    .opcode  (instr_i[31:26]),
    .ctrl    (lutCtrl),
    .usesRs  (usesRs),
    .usesRt  (usesRt),
    .illegal (lutIllegal)
  );

  // Only a load sitting in ID/EX can create a hazard; the bubble it forces clears it next cycle.
  assign hazardHit = validQ & ctrlQ.memRead & (rtQ != 5'd0) &
                     ((usesRs & (instr_i[25:21] == rtQ)) |
                      (usesRt & (instr_i[20:16] == rtQ)));
  assign stall_o     = HAZARD_EN & instr_valid_i & ~flush_i & hazardHit;
  assign loadBubble  = flush_i | stall_o | ~instr_valid_i | lutIllegal;
  assign takeIllegal = instr_valid_i & ~flush_i & ~stall_o & lutIllegal;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrlQ    <= '0;
      validQ   <= 1'b0;
      illegalQ <= 1'b0;
      rsQ      <= '0;
      rtQ      <= '0;
      rdQ      <= '0;
      immQ     <= '0;
      jaddrQ   <= '0;
      issuedQ  <= '0;
      bubbleQ  <= '0;
    end else if (loadBubble) begin
      ctrlQ    <= '0;
      validQ   <= 1'b0;
      illegalQ <= takeIllegal;
      rsQ      <= '0;
      rtQ      <= '0;
      rdQ      <= '0;
      immQ     <= '0;
      jaddrQ   <= '0;
      if (bubbleQ != CNT_MAX) bubbleQ <= bubbleQ + CNT_W'(1);
    end else begin
      ctrlQ    <= lutCtrl;
      validQ   <= 1'b1;
      illegalQ <= 1'b0;
      rsQ      <= instr_i[25:21];
      rtQ      <= instr_i[20:16];
      rdQ      <= instr_i[15:11];
      immQ     <= instr_i[15:0];
      jaddrQ   <= instr_i[25:0];
      if (issuedQ != CNT_MAX) issuedQ <= issuedQ + CNT_W'(1);
    end
  end

  assign valid_o         = validQ;
  assign reg_write_o     = ctrlQ.regWrite;
  assign alu_src_o       = ctrlQ.aluSrc;
  assign reg_dst_o       = ctrlQ.regDst;
  assign branch_o        = ctrlQ.branch;
  assign jump_o          = ctrlQ.jump;
  assign mem_read_o      = ctrlQ.memRead;
  assign mem_write_o     = ctrlQ.memWrite;
  assign is_ori_o        = ctrlQ.isOri;
  assign is_jal_o        = ctrlQ.isJal;
  assign read_data_reg_o = ctrlQ.readDataReg;
  assign alu_op_o        = ALU_OP_W'(ctrlQ.aluOp);
  assign branch_type_o   = ctrlQ.branchType;
  assign mem_to_reg_o    = ctrlQ.memToReg;
  assign rs_o            = rsQ;
  assign rt_o            = rtQ;
  assign rd_o            = rdQ;
  assign imm_o           = immQ;
  assign jaddr_o         = jaddrQ;
  assign illegal_o       = illegalQ;
  assign issued_cnt_o    = issuedQ;
  assign bubble_cnt_o    = bubbleQ;

endmodule

// File: tb/tb_pipe_decoder.sv
// Bench for pipe_decoder: directed scenarios plus randomized traffic against an
// instruction-level reference model; a second instance with CNT_W=2 exercises saturation.
module tb_pipe_decoder;

  typedef struct packed {
    logic        valid;
    logic        regWrite;
    logic        aluSrc;
    logic        regDst;
    logic        branch;
    logic        jump;
    logic        memRead;
    logic        memWrite;
    logic        isOri;
    logic        isJal;
    logic        readDataReg;
    logic [2:0]  aluOp;
    logic [1:0]  branchType;
    logic [1:0]  memToReg;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] jaddr;
    logic        illegal;
  } idEx_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] instr = '0;
  logic instrValid = 1'b0;
  logic flush = 1'b0;

  logic stall, valid, regWrite, aluSrc, regDst, branch, jump, memRead, memWrite;
  logic isOri, isJal, readDataReg, illegal;
  logic [2:0] aluOp;
  logic [1:0] branchType, memToReg;
  logic [4:0] rsF, rtF, rdF;
  logic [15:0] imm;
  logic [25:0] jaddr;
  logic [15:0] issuedCnt, bubbleCnt;

  logic sStall, sValid, sRegWrite, sAluSrc, sRegDst, sBranch, sJump, sMemRead, sMemWrite;
  logic sIsOri, sIsJal, sReadDataReg, sIllegal;
  logic [2:0] sAluOp;
  logic [1:0] sBranchType, sMemToReg;
  logic [4:0] sRs, sRt, sRd;
  logic [15:0] sImm;
  logic [25:0] sJaddr;
  logic [1:0] sIssuedCnt, sBubbleCnt;

  int checks = 0;
  int failures = 0;

  idEx_t exp;
  int issuedN = 0;
  int bubbleN = 0;
  bit expStall;

  always #5 clk = ~clk;

  pipe_decoder dut (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .instr_valid_i(instrValid), .flush_i(flush),
    .stall_o(stall), .valid_o(valid), .reg_write_o(regWrite), .alu_src_o(aluSrc),
    .reg_dst_o(regDst), .branch_o(branch), .jump_o(jump), .mem_read_o(memRead),
    .mem_write_o(memWrite), .is_ori_o(isOri), .is_jal_o(isJal),
    .read_data_reg_o(readDataReg), .alu_op_o(aluOp), .branch_type_o(branchType),
    .mem_to_reg_o(memToReg), .rs_o(rsF), .rt_o(rtF), .rd_o(rdF), .imm_o(imm),
    .jaddr_o(jaddr), .illegal_o(illegal), .issued_cnt_o(issuedCnt), .bubble_cnt_o(bubbleCnt)
  );

  pipe_decoder #(.CNT_W(2)) dutSat (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .instr_valid_i(instrValid), .flush_i(flush),
    .stall_o(sStall), .valid_o(sValid), .reg_write_o(sRegWrite), .alu_src_o(sAluSrc),
    .reg_dst_o(sRegDst), .branch_o(sBranch), .jump_o(sJump), .mem_read_o(sMemRead),
    .mem_write_o(sMemWrite), .is_ori_o(sIsOri), .is_jal_o(sIsJal),
    .read_data_reg_o(sReadDataReg), .alu_op_o(sAluOp), .branch_type_o(sBranchType),
    .mem_to_reg_o(sMemToReg), .rs_o(sRs), .rt_o(sRt), .rd_o(sRd), .imm_o(sImm),
    .jaddr_o(sJaddr), .illegal_o(sIllegal), .issued_cnt_o(sIssuedCnt), .bubble_cnt_o(sBubbleCnt)
  );

  // Instruction semantics straight from the opcode table; unknown opcodes read nothing.
  function automatic void refDecode(input logic [31:0] ins, output idEx_t d, output bit legal,
                                    output bit readsRs, output bit readsRt);
    d = '0;
    d.valid = 1'b1;
    d.rs = ins[25:21];
    d.rt = ins[20:16];
    d.rd = ins[15:11];
    d.imm = ins[15:0];
    d.jaddr = ins[25:0];
    d.readDataReg = 1'b1;
    legal = 1'b1;
    readsRs = 1'b1;
    readsRt = 1'b0;
    case (ins[31:26])
      6'b000000: begin d.aluOp = 3'b010; d.regDst = 1; d.regWrite = 1; readsRt = 1; end
      6'b001000: begin d.aluOp = 3'b110; d.regWrite = 1; d.aluSrc = 1; end
      6'b001010: begin d.aluOp = 3'b011; d.regWrite = 1; d.aluSrc = 1; end
      6'b001111: begin d.aluOp = 3'b100; d.regWrite = 1; d.aluSrc = 1; readsRs = 0; end
      6'b001101: begin d.aluOp = 3'b111; d.regWrite = 1; d.aluSrc = 1; d.isOri = 1; end
      6'b000100: begin d.aluOp = 3'b001; d.branch = 1; d.branchType = 2'b00; readsRt = 1; end
      6'b000101: begin d.aluOp = 3'b001; d.branch = 1; d.branchType = 2'b11; readsRt = 1; end
      6'b000111: begin d.aluOp = 3'b001; d.branch = 1; d.branchType = 2'b01; readsRt = 1; end
      6'b000001: begin d.aluOp = 3'b101; d.branch = 1; d.branchType = 2'b10; d.readDataReg = 0; end
      6'b100011: begin d.aluOp = 3'b110; d.regWrite = 1; d.aluSrc = 1; d.memRead = 1; d.memToReg = 2'b01; end
      6'b101011: begin d.aluOp = 3'b110; d.memWrite = 1; readsRt = 1; end
      6'b000010: begin d.jump = 1; readsRs = 0; end
      6'b000011: begin
        d.jump = 1; d.regWrite = 1; d.memToReg = 2'b11; d.isJal = 1; d.readDataReg = 0; readsRs = 0;
      end
      default: begin legal = 1'b0; readsRs = 0; readsRt = 0; end
    endcase
  endfunction

  function automatic idEx_t observed();
    idEx_t o;
    o = '{valid, regWrite, aluSrc, regDst, branch, jump, memRead, memWrite, isOri, isJal,
          readDataReg, aluOp, branchType, memToReg, rsF, rtF, rdF, imm, jaddr, illegal};
    return o;
  endfunction

  function automatic int satCnt(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic drive(input logic r, input logic [31:0] ins, input logic v, input logic f);
    idEx_t d;
    bit legal, readsRs, readsRt, depends;
    @(negedge clk);
    rst = r; instr = ins; instrValid = v; flush = f;
    #1;
    refDecode(ins, d, legal, readsRs, readsRt);
    depends = (readsRs && ins[25:21] == exp.rt) || (readsRt && ins[20:16] == exp.rt);
    expStall = v && !f && exp.valid && exp.memRead && exp.rt != 5'd0 && depends;
  endtask

  task automatic tick();
    idEx_t d;
    bit legal, readsRs, readsRt;
    @(posedge clk);
    refDecode(instr, d, legal, readsRs, readsRt);
    if (rst) begin
      exp = '0; issuedN = 0; bubbleN = 0;
    end else if (flush || expStall || !instrValid) begin
      exp = '0; bubbleN++;
    end else if (!legal) begin
      exp = '0; exp.illegal = 1'b1; bubbleN++;
    end else begin
      exp = d; issuedN++;
    end
    #1;
  endtask

  task automatic resetDut();
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    drive(1'b1, 32'h8C220000, 1'b1, 1'b0);
    tick();
    tick();
    checks++;
    if (observed() !== idEx_t'('0)) begin
      failures++; $display("FAIL reset_bundle: got %h want 0", observed());
    end
    checks++;
    if (stall !== 1'b0 || issuedCnt !== 16'd0 || bubbleCnt !== 16'd0 || sIssuedCnt !== 2'd0) begin
      failures++; $display("FAIL reset_counters: stall=%b issued=%0d bubble=%0d want 0 0 0", stall, issuedCnt, bubbleCnt);
    end
  endtask

  task automatic test_addi();
    resetDut();
    drive(1'b0, 32'h20010005, 1'b1, 1'b0);
    tick();
    checks++;
    if ({valid, regWrite, aluSrc, aluOp, rtF, imm} !== {1'b1, 1'b1, 1'b1, 3'b110, 5'd1, 16'd5}) begin
      failures++; $display("FAIL addi_fields: got v%b rw%b as%b op%b rt%0d imm%0d want 1 1 1 110 1 5",
                           valid, regWrite, aluSrc, aluOp, rtF, imm);
    end
    checks++;
    if (issuedCnt !== 16'd1) begin
      failures++; $display("FAIL addi_issued: got %0d want 1", issuedCnt);
    end
    checks++;
    if (observed() !== exp) begin
      failures++; $display("FAIL addi_bundle: got %h want %h", observed(), exp);
    end
  endtask

  task automatic test_load_use();
    resetDut();
    drive(1'b0, 32'h8C220000, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h00411820, 1'b1, 1'b0);
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL load_use_stall: got %b want 1", stall);
    end
    tick();
    checks++;
    if (valid !== 1'b0 || bubbleCnt !== 16'd1) begin
      failures++; $display("FAIL load_use_bubble: valid=%b bubble=%0d want 0 1", valid, bubbleCnt);
    end
    drive(1'b0, 32'h00411820, 1'b1, 1'b0);
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL load_use_restall: got %b want 0", stall);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || regDst !== 1'b1 || rdF !== 5'd3 || issuedCnt !== 16'd2) begin
      failures++; $display("FAIL load_use_issue: valid=%b regDst=%b rd=%0d issued=%0d want 1 1 3 2",
                           valid, regDst, rdF, issuedCnt);
    end
  endtask

  task automatic test_rt_zero();
    resetDut();
    drive(1'b0, 32'h8C200000, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h00011820, 1'b1, 1'b0);
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL rt_zero_stall: got %b want 0", stall);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || bubbleCnt !== 16'd0) begin
      failures++; $display("FAIL rt_zero_issue: valid=%b bubble=%0d want 1 0", valid, bubbleCnt);
    end
  endtask

  task automatic test_flush_hazard();
    resetDut();
    drive(1'b0, 32'h8C220000, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h10410004, 1'b1, 1'b1);
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL flush_stall: got %b want 0", stall);
    end
    tick();
    checks++;
    if (valid !== 1'b0 || branch !== 1'b0 || illegal !== 1'b0 || bubbleCnt !== 16'd1) begin
      failures++; $display("FAIL flush_bubble: valid=%b branch=%b illegal=%b bubble=%0d want 0 0 0 1",
                           valid, branch, illegal, bubbleCnt);
    end
  endtask

  task automatic test_illegal();
    resetDut();
    drive(1'b0, 32'hFC221234, 1'b1, 1'b0);
    tick();
    checks++;
    if (observed() !== idEx_t'(1)) begin
      failures++; $display("FAIL illegal_bundle: got %h want 1", observed());
    end
    drive(1'b0, 32'h34430F0F, 1'b1, 1'b0);
    tick();
    checks++;
    if (illegal !== 1'b0 || isOri !== 1'b1 || aluOp !== 3'b111) begin
      failures++; $display("FAIL illegal_clear: illegal=%b isOri=%b op=%b want 0 1 111", illegal, isOri, aluOp);
    end
  endtask

  task automatic test_jal();
    resetDut();
    drive(1'b0, 32'h0C000040, 1'b1, 1'b0);
    tick();
    checks++;
    if ({jump, memToReg, isJal, regWrite, readDataReg, jaddr} !== {1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 26'h40}) begin
      failures++; $display("FAIL jal_fields: j%b mtr%b jal%b rw%b rdr%b ja%h want 1 11 1 1 0 40",
                           jump, memToReg, isJal, regWrite, readDataReg, jaddr);
    end
  endtask

  task automatic test_saturation();
    resetDut();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h20010005 + 32'(i), 1'b1, 1'b0);
      tick();
    end
    checks++;
    if (sIssuedCnt !== 2'd3 || issuedCnt !== 16'd5) begin
      failures++; $display("FAIL saturation: narrow=%0d wide=%0d want 3 5", sIssuedCnt, issuedCnt);
    end
  endtask

  task automatic test_back_to_back();
    int stalls;
    logic [31:0] prog [3];
    prog[0] = 32'h8C220000;
    prog[1] = 32'h8C430000;
    prog[2] = 32'h00632020;
    resetDut();
    stalls = 0;
    for (int pc = 0; pc < 3; ) begin
      drive(1'b0, prog[pc], 1'b1, 1'b0);
      if (stall === 1'b1) stalls++;
      if (stall !== 1'b1) pc++;
      tick();
    end
    checks++;
    if (stalls != 2 || bubbleCnt !== 16'd2 || issuedCnt !== 16'd3) begin
      failures++; $display("FAIL back_to_back: stalls=%0d bubble=%0d issued=%0d want 2 2 3", stalls, bubbleCnt, issuedCnt);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [15];
    logic [31:0] cur, rnd;
    bit r, prevStall;
    ops = '{6'h00, 6'h08, 6'h0A, 6'h0F, 6'h0D, 6'h04, 6'h05, 6'h07, 6'h01,
            6'h23, 6'h23, 6'h2B, 6'h02, 6'h03, 6'h3F};
    resetDut();
    cur = 32'h0;
    prevStall = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!expStall || n == 0) begin
        rnd = $urandom();
        cur = {ops[$urandom_range(0, 14)], 3'b000, rnd[1:0], 3'b000, rnd[3:2], rnd[15:0]};
      end
      r = ($urandom_range(0, 59) == 0);
      drive(r, cur, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0);
      if (!r) begin
        checks++;
        if (stall !== expStall) begin
          failures++; $display("FAIL rand_stall[%0d]: got %b want %b", n, stall, expStall);
        end
        checks++;
        if (stall === 1'b1 && prevStall) begin
          failures++; $display("FAIL rand_double_stall[%0d]: got 1 want 0", n);
        end
      end
      prevStall = !r && stall === 1'b1;
      tick();
      checks++;
      if (observed() !== exp) begin
        failures++; $display("FAIL rand_bundle[%0d]: got %h want %h", n, observed(), exp);
      end
      checks++;
      if (issuedCnt !== 16'(satCnt(issuedN, 16)) || bubbleCnt !== 16'(satCnt(bubbleN, 16)) ||
          sIssuedCnt !== 2'(satCnt(issuedN, 2)) || sBubbleCnt !== 2'(satCnt(bubbleN, 2))) begin
        failures++; $display("FAIL rand_counters[%0d]: got %0d/%0d %0d/%0d want %0d/%0d %0d/%0d", n,
                             issuedCnt, bubbleCnt, sIssuedCnt, sBubbleCnt, satCnt(issuedN, 16),
                             satCnt(bubbleN, 16), satCnt(issuedN, 2), satCnt(bubbleN, 2));
      end
    end
  endtask

  initial begin
    exp = '0;
    expStall = 1'b0;
    test_reset();
    test_addi();
    test_load_use();
    test_rt_zero();
    test_flush_hazard();
    test_illegal();
    test_jal();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_decoder.md
# pipe_decoder

Registered, hazard-aware successor to the single-cycle control decoder; sits between the IF/ID register and the EX stage of the pipelined MIPS core. Decodes one 32-bit instruction per cycle into the full control bundle plus register and immediate fields, holds them in an internal ID/EX register, and detects load-use hazards against its own previously issued instruction. Undefined opcodes issue a bubble and flag `illegal_o` instead of driving X. Saturating issue and bubble counters support CPI measurement.

## Interface
- `ALU_OP_W`, 3: ALU op field width, ≥3; narrower codes are zero-extended.
- `CNT_W`, 16: width of each performance counter.
- `HAZARD_EN`, 1: 1 enables load-use detection; 0 ties `stall_o` to 0.
- `clk_i` in 1: clock; one clock domain.
- `rst_i` in 1: reset, synchronous, active-high.
- `instr_i` in 32: instruction from IF/ID.
- `instr_valid_i` in 1: `instr_i` is a real instruction.
- `flush_i` in 1: branch/jump resolved taken; kill the instruction in ID.
- `stall_o` out 1: combinational; IF and IF/ID hold this cycle.
- `valid_o` out 1: ID/EX entry is a real instruction.
- `reg_write_o`, `alu_src_o`, `reg_dst_o`, `branch_o`, `jump_o`, `mem_read_o`, `mem_write_o`, `is_ori_o`, `is_jal_o`, `read_data_reg_o` out 1 each: registered controls.
- `alu_op_o` out ALU_OP_W; `branch_type_o` out 2; `mem_to_reg_o` out 2.
- `rs_o`, `rt_o`, `rd_o` out 5; `imm_o` out 16; `jaddr_o` out 26.
- `illegal_o` out 1: registered; the last decoded opcode was undefined.
- `issued_cnt_o`, `bubble_cnt_o` out CNT_W: saturating counters.

## Operation
- Opcode map (ALU op / extra): R-type 000000 → 010, reg_dst=1. addi 001000 → 110. slti 001010 → 011. lui 001111 → 100. ori 001101 → 111, is_ori=1. These five plus lw set reg_write=1; all except R-type set alu_src=1.
- beq 000100 → 001, type 00. bne 000101 → 001, type 11. bgt 000111 → 001, type 01. bgez 000001 → 101, type 10, read_data_reg=0. All four set branch=1.
- lw 100011 → 110, mem_read=1, mem_to_reg=01. sw 101011 → 110, mem_write=1.
- j 000010 → jump=1. jal 000011 → jump=1, reg_write=1, mem_to_reg=11, is_jal=1.
- `read_data_reg=1` for every defined opcode except bgez and jal. Any field not listed above is 0.
- Bubble: every control, including valid, is 0; fields are don't-care but driven to 0.
- Source use: rs is read by every opcode except lui, j and jal. rt is read by R-type, beq, bne, bgt and sw.
- Load-use: `stall_o` = HAZARD_EN & instr_valid_i & !flush_i & valid_o & mem_read_o & (rt_o != 0) & ((uses_rs & rs == rt_o) | (uses_rt & rt == rt_o)).
- Register update priority: rst_i > flush_i > stall_o > !instr_valid_i > illegal opcode > decode. The first four load a bubble; an illegal opcode loads a bubble with illegal_o=1. illegal_o is otherwise 0.
- Implicit two-state FSM, RUN ↔ BUBBLE-after-stall. A stall inserts exactly one bubble. The next cycle the bubble clears the hazard, so stall_o is never high two consecutive cycles.
- Counters: issued increments on each valid load; bubble increments on each bubble load except during reset. Both saturate at 2^CNT_W−1 and do not wrap.

## Timing
- Decode latency 1 cycle: instruction sampled at edge N appears on outputs after edge N.
- stall_o is a same-cycle combinational path from instr_i and the registered state.
- Reset: all outputs 0, counters 0, stall_o 0. Reset asserted mid-stall drops the held instruction.
- flush_i together with stall_o: flush wins, stall_o=0, and a bubble is loaded.
- Back-to-back lw then dependent instruction gives 1 stall. lw with rt=0 never stalls.

## Structure
- Shared package `mips_ctrl_pkg` holds the opcode constants, ALU op codes, branch-type encodings (EQ 00, GT 01, GEZ 10, NE 11), mem_to_reg encodings, and a packed control-bundle struct.
- Sub-module `ctrl_lut`: pure combinational opcode → bundle lookup with uses_rs, uses_rt and illegal outputs. The parent holds the ID/EX register, hazard logic and counters.

## Test plan
- Reset, then addi $1,$0,5 (0x20010005) valid: next cycle valid_o=1, reg_write=1, alu_src=1, alu_op=110, rt_o=1, imm_o=5, issued=1.
- lw $2,0($1), then add $3,$2,$1: stall_o=1 in the add's ID cycle, one bubble, add issues a cycle later, bubble_cnt=1.
- lw $0,0($1), then add $3,$0,$1: no stall.
- beq decoded while flush_i=1 and a hazard is present: stall_o=0, bubble loaded.
- Opcode 111111: valid_o=0, illegal_o=1, all controls 0. The next cycle, with a legal opcode, illegal_o=0.
- CNT_W=2, 5 valid instructions: issued_cnt_o saturates at 3. jal: jump=1, mem_to_reg=11, is_jal=1, reg_write=1.
